// File: rtl/dlock_ctrl_if.sv
// Attempt handshake and result bundle between a requester and dlock_ctrl.
// The requester offers a code word; the controller returns a one-cycle result pulse.
interface dlock_ctrl_if;
   logic [5:0] code;
   logic       code_valid;
   logic       code_ready;
   logic       result_valid;
   logic       result_ok;

   modport master (
      output code,
      output code_valid,
      input  code_ready,
      input  result_valid,
      input  result_ok
   );

   modport slave (
      input  code,
      input  code_valid,
      output code_ready,
      output result_valid,
      output result_ok
   );
endinterface

// File: rtl/dlock_ctrl.sv
// Attempt controller for the serial combination lock: clears the lock, shifts a
// 6-bit code MSB-first, grades the attempt, and manages door-open and lockout windows.
module dlock_ctrl #(
   parameter int unsigned MAX_FAIL       = 3,
   parameter int unsigned LOCKOUT_CYCLES = 16,
   parameter int unsigned OPEN_CYCLES    = 8
) (
   input  logic        clk,
   input  logic        clear,
   dlock_ctrl_if.slave req,
   input  logic        relock,
   output logic        lock_b_in,
   output logic        lock_clear_n,
   input  logic        lock_unlock,
   output logic        door_open,
   output logic        locked_out,
   output logic [3:0]  fail_count
);

   localparam int unsigned TMAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] OPEN_LD  = TW'(OPEN_CYCLES);
   localparam logic [TW-1:0] LOCK_LD  = TW'(LOCKOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_1  = TW'(1);
   localparam logic [4:0]    FAIL_LIM = 5'(MAX_FAIL);
   localparam logic [3:0]    FAIL_SAT = 4'(MAX_FAIL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_SHIFT,
      S_CHECK,
      S_OPEN,
      S_LOCKOUT
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    code_q, code_d;
   logic [2:0]    idx_q, idx_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    fail_q, fail_d;
   logic          b_in_q, b_in_d;
   logic          clr_n_q, clr_n_d;
   logic          rv_q, rv_d;
   logic          rok_q, rok_d;
   logic          door_q, door_d;
   logic          lock_q, lock_d;
   logic          ready;
   logic [4:0]    fail_inc;

   // Gated by clear so no handshake can be taken while reset is held.
   assign ready    = (state_q == S_IDLE) && !clear;
   assign fail_inc = {1'b0, fail_q} + 5'd1;

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      idx_d   = idx_q;
      timer_d = timer_q;
      fail_d  = fail_q;
      rv_d    = 1'b0;
      rok_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req.code_valid && ready) begin
               code_d  = req.code;
               state_d = S_CLR;
            end
         end
         S_CLR: begin
            idx_d   = 3'd5;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (idx_q == 3'd0) begin
               state_d = S_CHECK;
            end else begin
               idx_d = idx_q - 3'd1;
            end
         end
         S_CHECK: begin
            rv_d  = 1'b1;
            rok_d = lock_unlock;
            if (lock_unlock) begin
               fail_d  = '0;
               timer_d = OPEN_LD;
               state_d = S_OPEN;
            end else if (fail_inc == FAIL_LIM) begin
               fail_d  = FAIL_SAT;
               timer_d = LOCK_LD;
               state_d = S_LOCKOUT;
            end else begin
               fail_d  = fail_inc[3:0];
               state_d = S_IDLE;
            end
         end
         S_OPEN: begin
            if (relock || (timer_q <= TIMER_1)) begin
               timer_d = '0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q - TIMER_1;
            end
         end
         S_LOCKOUT: begin
            if (timer_q <= TIMER_1) begin
               timer_d = '0;
               fail_d  = '0;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q - TIMER_1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Lock-facing outputs are registered, so decode them from the next state.
      clr_n_d = (state_d == S_SHIFT) || (state_d == S_CHECK) || (state_d == S_OPEN);
      b_in_d  = (state_d == S_SHIFT) ? code_q[idx_d] : 1'b0;
      door_d  = (state_d == S_OPEN);
      lock_d  = (state_d == S_LOCKOUT);
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= S_IDLE;
         code_q  <= '0;
         idx_q   <= '0;
         timer_q <= '0;
         fail_q  <= '0;
         b_in_q  <= 1'b0;
         clr_n_q <= 1'b0;
         rv_q    <= 1'b0;
         rok_q   <= 1'b0;
         door_q  <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         idx_q   <= idx_d;
         timer_q <= timer_d;
         fail_q  <= fail_d;
         b_in_q  <= b_in_d;
         clr_n_q <= clr_n_d;
         rv_q    <= rv_d;
         rok_q   <= rok_d;
         door_q  <= door_d;
         lock_q  <= lock_d;
      end
   end

   assign req.code_ready   = ready;
   assign req.result_valid = rv_q;
   assign req.result_ok    = rok_q;
   assign lock_b_in        = b_in_q;
   assign lock_clear_n     = clr_n_q;
   assign door_open        = door_q;
   assign locked_out       = lock_q;
   assign fail_count       = fail_q;

endmodule

// File: tb/tb_dlock_ctrl.sv
// Scoreboard bench for dlock_ctrl with a behavioural serial lock whose secret is 101100.
module tb_dlock_ctrl;

   typedef struct packed {
      logic        ok;
      logic [3:0]  fc;
      logic        lk;
      logic [31:0] due;
   } exp_t;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       relock = 1'b0;
   logic       lock_b_in;
   logic       lock_clear_n;
   logic       lock_unlock;
   logic       door_open;
   logic       locked_out;
   logic [3:0] fail_count;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   exp_t sb[$];
   exp_t mon_e;

   logic [5:0] secret = 6'b101100;
   logic [2:0] lk_cnt = 3'd0;
   logic       lk_ok  = 1'b1;

   dlock_ctrl_if bus ();

   dlock_ctrl #(
      .MAX_FAIL      (3),
      .LOCKOUT_CYCLES(16),
      .OPEN_CYCLES   (8)
   ) dut (
      .clk         (clk),
      .clear       (clear),
      .req         (bus.slave),
      .relock      (relock),
      .lock_b_in   (lock_b_in),
      .lock_clear_n(lock_clear_n),
      .lock_unlock (lock_unlock),
      .door_open   (door_open),
      .locked_out  (locked_out),
      .fail_count  (fail_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Serial lock: samples b_in on the falling edge, unlocks only after six matching bits.
   always @(negedge clk) begin
      if (!lock_clear_n) begin
         lk_cnt <= 3'd0;
         lk_ok  <= 1'b1;
      end else if (lk_cnt < 3'd6) begin
         lk_ok  <= lk_ok & (lock_b_in == secret[3'd5 - lk_cnt]);
         lk_cnt <= lk_cnt + 3'd1;
      end
   end
   assign lock_unlock = (lk_cnt == 3'd6) && lk_ok;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus.result_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got result_ok=%0d with no attempt pending (cycle %0d)",
                     bus.result_ok, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("result_ok", 32'(bus.result_ok), 32'(mon_e.ok));
            chk("fail_count", 32'(fail_count), 32'(mon_e.fc));
            chk("door_open_at_result", 32'(door_open), 32'(mon_e.ok));
            chk("locked_out_at_result", 32'(locked_out), 32'(mon_e.lk));
            chk("code_ready_at_result", 32'(bus.code_ready), 32'(!mon_e.ok && !mon_e.lk));
            chk("latency", 32'(cyc), mon_e.due);
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_clear_n"}, 32'(lock_clear_n), 0);
      chk({tag, "_b_in"}, 32'(lock_b_in), 0);
      chk({tag, "_result_valid"}, 32'(bus.result_valid), 0);
      chk({tag, "_result_ok"}, 32'(bus.result_ok), 0);
      chk({tag, "_door_open"}, 32'(door_open), 0);
      chk({tag, "_locked_out"}, 32'(locked_out), 0);
      chk({tag, "_fail_count"}, 32'(fail_count), 0);
   endtask

   // Returns at the falling edge just after the handshake edge.
   task automatic offer(input logic [5:0] c, input logic push, input logic ok,
                        input logic [3:0] fc, input logic lk, input logic hold);
      int n = 0;
      @(negedge clk);
      while (bus.code_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("code_ready_wait", 32'(bus.code_ready), 1);
      bus.code       = c;
      bus.code_valid = 1'b1;
      @(posedge clk);
      #1;
      if (push) sb.push_back('{ok, fc, lk, 32'(cyc + 8)});
      @(negedge clk);
      if (hold) bus.code = '0;
      else      bus.code_valid = 1'b0;
   endtask

   task automatic wait_result();
      int n = 0;
      while (bus.result_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("result_wait", 32'(bus.result_valid), 1);
   endtask

   task automatic measure_door(input int relock_at, input int exp_len);
      int cnt = 0;
      while (door_open === 1'b1 && cnt < 100) begin
         cnt++;
         if (cnt == relock_at) relock = 1'b1;
         @(negedge clk);
         relock = 1'b0;
      end
      chk("door_len", 32'(cnt), 32'(exp_len));
      chk("ready_after_door", 32'(bus.code_ready), 1);
      chk("fail_count_after_open", 32'(fail_count), 0);
   endtask

   initial begin
      int cnt;
      bus.code       = '0;
      bus.code_valid = 1'b0;

      repeat (3) @(negedge clk);
      check_reset("rst");
      clear = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(bus.code_ready), 1);

      offer(6'b101100, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
      wait_result();
      measure_door(0, 8);

      offer(6'b110100, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
      wait_result();

      // Clear during the third SHIFT cycle, with fail_count still at 1.
      offer(6'b101100, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("b_in_shift3", 32'(lock_b_in), 1);
      chk("clear_n_shift3", 32'(lock_clear_n), 1);
      clear = 1'b1;
      @(negedge clk);
      check_reset("midclr");
      clear = 1'b0;
      @(negedge clk);
      chk("ready_after_midclr", 32'(bus.code_ready), 1);
      offer(6'b101100, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
      wait_result();
      measure_door(0, 8);

      offer(6'b111111, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
      wait_result();
      offer(6'b000000, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
      wait_result();
      offer(6'b001101, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
      wait_result();
      cnt = 0;
      while (locked_out === 1'b1 && cnt < 100) begin
         cnt++;
         if (cnt >= 2 && cnt <= 6) begin
            bus.code       = 6'b101100;
            bus.code_valid = 1'b1;
            chk("ready_in_lockout", 32'(bus.code_ready), 0);
         end else begin
            bus.code_valid = 1'b0;
         end
         @(negedge clk);
      end
      bus.code_valid = 1'b0;
      chk("lockout_len", 32'(cnt), 16);
      chk("fail_count_after_lockout", 32'(fail_count), 0);
      chk("ready_after_lockout", 32'(bus.code_ready), 1);

      offer(6'b110100, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
      wait_result();
      offer(6'b000000, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
      wait_result();
      offer(6'b101100, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
      wait_result();
      measure_door(0, 8);

      offer(6'b101100, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
      wait_result();
      measure_door(3, 3);

      // code_valid stays high with a wrong code after the handshake; only the first is graded.
      offer(6'b101100, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
      wait_result();
      bus.code_valid = 1'b0;
      measure_door(0, 8);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
      $fatal(1, "watchdog");
   end

endmodule
